// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: one-hot column drive, debounced key capture, one-cycle key_evt on accept.
// Latency: row input to accepted code is 2 sync cycles plus DEB_CNT scan ticks; no backpressure.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] data,
    output logic       key_evt
);
    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [1:0] S_SCAN    = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [3:0]    rs_meta;
    logic [3:0]    rs_n;
    logic [CW-1:0] pre;
    logic          tick;
    logic [1:0]    state;
    logic [1:0]    c;
    logic [1:0]    rr;
    logic [3:0]    deb;
    logic [3:0]    deb_inc;
    logic [3:0]    low;
    logic          hit;
    logic [1:0]    hit_row;
    logic          cap_low;
    logic [3:0]    code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta <= 4'b1111;
            rs_n    <= 4'b1111;
        end else begin
            rs_meta <= row_n;
            rs_n    <= rs_meta;
        end
    end

    assign tick = (pre == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre <= '0;
        else if (tick)
            pre <= '0;
        else
            pre <= pre + CW'(1);
    end

    assign col_n = ~(4'b0001 << c);

    // Row 3 at column 3 is the reserved key; masking it before the priority pick
    // lets a simultaneous lower row in that column still be seen.
    always_comb begin
        low = ~rs_n;
        if (c == 2'd3)
            low[3] = 1'b0;
        hit     = 1'b0;
        hit_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (low[i]) begin
                hit     = 1'b1;
                hit_row = 2'(i);
            end
        end
    end

    assign cap_low = ~rs_n[rr];
    assign code    = {rr, c} + 4'd1;
    assign deb_inc = deb + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_SCAN;
            c       <= 2'd0;
            rr      <= 2'd0;
            deb     <= 4'd0;
            data    <= 4'h0;
            key_evt <= 1'b0;
        end else begin
            key_evt <= 1'b0;
            if (tick) begin
                case (state)
                    S_SCAN: begin
                        if (hit) begin
                            rr    <= hit_row;
                            deb   <= 4'd1;
                            state <= S_DEBOUNCE;
                        end else begin
                            c <= c + 2'd1;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (cap_low) begin
                            deb <= deb_inc;
                            if (deb_inc == 4'(DEB_CNT)) begin
                                state   <= S_HELD;
                                data    <= code;
                                key_evt <= 1'b1;
                            end
                        end else begin
                            deb   <= 4'd0;
                            state <= S_SCAN;
                            c     <= c + 2'd1;
                        end
                    end
                    S_HELD: begin
                        if (!cap_low) begin
                            deb   <= 4'd1;
                            state <= S_RELEASE;
                        end
                    end
                    default: begin
                        if (!cap_low) begin
                            deb <= deb_inc;
                            if (deb_inc == 4'(DEB_CNT)) begin
                                deb   <= 4'd0;
                                data  <= 4'h0;
                                state <= S_SCAN;
                                c     <= c + 2'd1;
                            end
                        end else begin
                            deb   <= 4'd0;
                            state <= S_HELD;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Drives a simulated 4x4 key matrix and checks col_n/data/key_evt against a tick-level keypad model.
module tb_keypad_scan;
    localparam int DIV = 4;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] data;
    logic       key_evt;

    // bit r*4+c set means the key at row r, column c is physically held down
    logic [15:0] pressed = 16'h0000;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_col[$];
    logic [3:0] exp_dat[$];

    int m_col, m_held, m_arm, m_row, m_streak, m_rel;

    keypad_scan #(.SCAN_DIV(DIV), .DEB_CNT(DEB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .row_n  (row_n),
        .col_n  (col_n),
        .data   (data),
        .key_evt(key_evt)
    );

    always #5 clk = ~clk;

    // A row line is pulled low through any held key whose column is being driven.
    assign row_n[0] = ~|(pressed[3:0]   & ~col_n);
    assign row_n[1] = ~|(pressed[7:4]   & ~col_n);
    assign row_n[2] = ~|(pressed[11:8]  & ~col_n);
    assign row_n[3] = ~|(pressed[15:12] & ~col_n);

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_held = 0; m_arm = 0; m_row = 0; m_streak = 0; m_rel = 0;
    endtask

    task automatic model_advance();
        m_col = (m_col + 1) % 4;
        exp_col.push_back(~(4'b0001 << m_col));
    endtask

    // One scan tick of the keypad as seen by a user: the model looks only at which keys are down.
    task automatic model_step(input logic [15:0] p);
        int found;
        if (m_held != 0) begin
            if (p[m_row*4 + m_col]) begin
                m_rel = 0;
            end else begin
                m_rel++;
                if (m_rel == DEB) begin
                    m_held = 0;
                    m_rel  = 0;
                    exp_dat.push_back(4'h0);
                    model_advance();
                end
            end
        end else if (m_arm != 0) begin
            if (p[m_row*4 + m_col]) begin
                m_streak++;
                if (m_streak == DEB) begin
                    m_arm  = 0;
                    m_rel  = 0;
                    m_held = m_row*4 + m_col + 1;
                    exp_dat.push_back(4'(m_held));
                end
            end else begin
                m_arm = 0;
                model_advance();
            end
        end else begin
            found = -1;
            for (int r = 3; r >= 0; r--)
                if (p[r*4 + m_col] && !(r == 3 && m_col == 3))
                    found = r;
            if (found >= 0) begin
                m_arm    = 1;
                m_row    = found;
                m_streak = 1;
            end else begin
                model_advance();
            end
        end
    endtask

    task automatic tick_step();
        repeat (DIV) @(posedge clk);
        #1;
        model_step(pressed);
    endtask

    task automatic hold(input logic [15:0] p, input int n);
        pressed = p;
        repeat (n) tick_step();
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_col_n", col_n, 4'b1110);
        check("rst_data", data, 4'h0);
        check("rst_key_evt", {3'b000, key_evt}, 4'h0);
        model_reset();
        exp_col.delete();
        exp_dat.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [3:0] prev_col = 4'b1110;
    logic [3:0] prev_dat = 4'h0;
    logic       evt_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_col = 4'b1110;
            prev_dat = 4'h0;
        end else begin
            if (col_n != prev_col) begin
                tests++;
                if (exp_col.size() == 0) begin
                    fails++;
                    $display("FAIL col_step: got %b, expected no column change", col_n);
                end else begin
                    logic [3:0] e;
                    e = exp_col.pop_front();
                    if (col_n !== e) begin
                        fails++;
                        $display("FAIL col_step: got %b, expected %b", col_n, e);
                    end
                end
            end
            evt_exp = (data != prev_dat) && (prev_dat == 4'h0) && (data != 4'h0);
            if (key_evt || evt_exp) begin
                tests++;
                if (key_evt !== evt_exp) begin
                    fails++;
                    $display("FAIL key_evt: got %b, expected %b (data %h prev %h)", key_evt, evt_exp, data, prev_dat);
                end
            end
            if (data != prev_dat) begin
                tests++;
                if (exp_dat.size() == 0) begin
                    fails++;
                    $display("FAIL data_step: got %h, expected no data change", data);
                end else begin
                    logic [3:0] e;
                    e = exp_dat.pop_front();
                    if (data !== e) begin
                        fails++;
                        $display("FAIL data_step: got %h, expected %h", data, e);
                    end
                end
            end
            prev_col = col_n;
            prev_dat = data;
        end
    end

    initial begin
        model_reset();
        reset_pulse();

        hold(16'h0000, 8);                    // idle scanning
        hold(16'h0040, 12);                   // key 7 (row 1, col 2) accepted and held
        hold(16'h0000, 2);                    // short release is absorbed
        hold(16'h0040, 3);
        hold(16'h0000, 5);                    // full release, scan resumes
        hold(16'h0000, 3);
        hold(16'h0001, 1);                    // one-tick glitch on key 1
        hold(16'h0000, 6);
        hold(16'h2200, 10);                   // rows 2 and 3 in column 1: key A wins
        hold(16'h0000, 5);
        hold(16'h8000, 10);                   // reserved key never accepted
        hold(16'h0000, 2);
        hold(16'h0040, 12);
        check("held_before_reset", data, 4'h7);
        reset_pulse();
        hold(16'h0040, 12);                   // same key must be re-debounced from column 0
        hold(16'h0000, 5);
        hold(16'h0200, 8);
        hold(16'h0002, 6);                    // different key during hold is ignored
        hold(16'h0000, 6);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: pressed = 16'h0000;
                    1, 2: pressed = 16'h0001 << $urandom_range(0, 15);
                    default: pressed = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                endcase
            end
            tick_step();
        end

        hold(16'h0000, 8);
        @(negedge clk);
        @(negedge clk);
        check("col_queue_drained", 4'(exp_col.size()), 4'h0);
        check("data_queue_drained", 4'(exp_dat.size()), 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
